// File: rtl/axis_counter_checker.sv
// AXI4-Stream sink that checks an incoming 0..N counter ramp, counting beats and mismatches.
// Optional first-mismatch capture is enabled with `define AXIS_COUNTER_CHECKER_FIRST_ERR_EN.
module axis_counter_checker #(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    CNTR_WIDTH       = 32,
  parameter string CONTINUOUS       = "FALSE",
  parameter int    ERR_WIDTH        = 16,
  parameter int    STS_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [STS_WIDTH-1:0]        sts_count,
  output logic [ERR_WIDTH-1:0]        sts_errors,
  output logic                        sts_done,
  output logic [STS_WIDTH-1:0]        sts_err_index,
  output logic [CNTR_WIDTH-1:0]       sts_err_data,
  output logic [1:0]                  dbg_state
);

  // Handshake: a beat transfers on a rising edge where s_axis_tvalid and
  // s_axis_tready are both high; tready depends only on the state register.

  localparam bit CONT = (CONTINUOUS == "TRUE");

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [CNTR_WIDTH-1:0] cfg_reg;
  logic [CNTR_WIDTH-1:0] exp_reg, exp_next;
  logic [CNTR_WIDTH-1:0] d;
  logic [CNTR_WIDTH-1:0] r;
  logic                  accept;
  logic                  mismatch;

  assign d             = s_axis_tdata[CNTR_WIDTH-1:0];
  assign s_axis_tready = (state == RUN);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign mismatch      = accept & (d != exp_reg);
  assign sts_done      = (state == DONE);
  assign dbg_state     = state;

  generate
    if (AXIS_TDATA_WIDTH > CNTR_WIDTH) begin : g_hi
      logic unused_tdata_hi;
      assign unused_tdata_hi = ^s_axis_tdata[AXIS_TDATA_WIDTH-1:CNTR_WIDTH];
    end
  endgenerate

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cfg_reg <= '0;
      state   <= IDLE;
      exp_reg <= '0;
    end else begin
      cfg_reg <= cfg_data;
      state   <= state_next;
      exp_reg <= exp_next;
    end
  end

  // A mismatching beat resynchronises the ramp to the received value.
  always_comb begin
    state_next = state;
    exp_next   = exp_reg;
    r          = (d != exp_reg) ? d : exp_reg;
    case (state)
      IDLE: begin
        if (cfg_reg != '0) begin
          state_next = RUN;
          exp_next   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (r < cfg_reg) begin
            exp_next = r + CNTR_WIDTH'(1);
          end else if (CONT) begin
            exp_next = '0;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sts_count  <= '0;
      sts_errors <= '0;
    end else if (accept) begin
      sts_count <= sts_count + STS_WIDTH'(1);
      if (mismatch && (sts_errors != {ERR_WIDTH{1'b1}})) begin
        sts_errors <= sts_errors + ERR_WIDTH'(1);
      end
    end
  end

`ifdef AXIS_COUNTER_CHECKER_FIRST_ERR_EN
  logic err_seen;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_seen      <= 1'b0;
      sts_err_index <= '0;
      sts_err_data  <= '0;
    end else if (mismatch && !err_seen) begin
      err_seen      <= 1'b1;
      sts_err_index <= sts_count;
      sts_err_data  <= d;
    end
  end
`else
  assign sts_err_index = '0;
  assign sts_err_data  = '0;
`endif

endmodule

// File: tb/tb_axis_counter_checker.sv
// Directed bench for axis_counter_checker: single pass, wrap, resync, gaps,
// zero config with mid-run reset, and error-counter saturation.
module tb_axis_counter_checker;

`ifdef AXIS_COUNTER_CHECKER_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] cfg = '0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;

  // u_single: one-pass, 16-bit counter compared inside 32-bit tdata
  logic        ready_s, done_s;
  logic [31:0] count_s, eidx_s;
  logic [15:0] errors_s, edata_s;
  logic [1:0]  st_s;
  // u_cont: continuous, default widths
  logic        ready_c, done_c;
  logic [31:0] count_c, eidx_c, edata_c;
  logic [15:0] errors_c;
  logic [1:0]  st_c;
  // u_sat: continuous, 2-bit error counter
  logic        ready_t, done_t;
  logic [31:0] count_t, eidx_t, edata_t;
  logic [1:0]  errors_t;
  logic [1:0]  st_t;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_counter_checker #(
    .AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16), .CONTINUOUS("FALSE"),
    .ERR_WIDTH(16), .STS_WIDTH(32)
  ) u_single (
    .aclk(aclk), .areset(areset), .cfg_data(cfg[15:0]),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(ready_s),
    .sts_count(count_s), .sts_errors(errors_s), .sts_done(done_s),
    .sts_err_index(eidx_s), .sts_err_data(edata_s), .dbg_state(st_s)
  );

  axis_counter_checker #(
    .AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32), .CONTINUOUS("TRUE"),
    .ERR_WIDTH(16), .STS_WIDTH(32)
  ) u_cont (
    .aclk(aclk), .areset(areset), .cfg_data(cfg),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(ready_c),
    .sts_count(count_c), .sts_errors(errors_c), .sts_done(done_c),
    .sts_err_index(eidx_c), .sts_err_data(edata_c), .dbg_state(st_c)
  );

  axis_counter_checker #(
    .AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32), .CONTINUOUS("TRUE"),
    .ERR_WIDTH(2), .STS_WIDTH(32)
  ) u_sat (
    .aclk(aclk), .areset(areset), .cfg_data(cfg),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(ready_t),
    .sts_count(count_t), .sts_errors(errors_t), .sts_done(done_t),
    .sts_err_index(eidx_t), .sts_err_data(edata_t), .dbg_state(st_t)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ready_s;
      1:       return ready_c;
      default: return ready_t;
    endcase
  endfunction

  // Assert reset for two cycles with cfg already applied, release on a falling edge.
  task automatic do_reset(input logic [31:0] cfg_val);
    @(negedge aclk);
    areset = 1'b1;
    tvalid = 1'b0;
    tdata  = '0;
    cfg    = cfg_val;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  // Present one beat; returns just after the rising edge that accepts it.
  task automatic send_beat(input int sel, input logic [31:0] data);
    int n;
    n = 0;
    @(negedge aclk);
    tdata  = data;
    tvalid = 1'b1;
    while (!rdy(sel) && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) check("beat_timeout", 64'(n), 64'd0);
    @(posedge aclk);
  endtask

  task automatic go_idle();
    @(negedge aclk);
    tvalid = 1'b0;
  endtask

  task automatic check_single_zero(input string tag);
    check({tag, "_ready"},  ready_s,  0);
    check({tag, "_count"},  count_s,  0);
    check({tag, "_errors"}, errors_s, 0);
    check({tag, "_done"},   done_s,   0);
    check({tag, "_eidx"},   eidx_s,   0);
    check({tag, "_edata"},  edata_s,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] val;
    logic        saw;
    int          acc;
    logic [1:0]  sat_exp [6];
    logic [31:0] sat_seq [6];
    logic [31:0] mis_seq [6];

    // ---- single pass, correct ramp (upper tdata bits are don't-care) ----
    do_reset(32'd5);
    areset = 1'b1;
    #1;
    check_single_zero("reset");
    check("reset_cont_count", count_c, 0);
    check("reset_sat_errors", errors_t, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("ready_after_edge1", ready_s, 0);
    @(negedge aclk);
    check("ready_after_edge2", ready_s, 1);
    for (int i = 0; i <= 5; i++) begin
      send_beat(0, {16'($urandom_range(0, 65535)), 16'(i)});
    end
    @(negedge aclk);
    check("single_ready_low", ready_s, 0);
    check("single_done", done_s, 1);
    tdata  = 32'd6;
    tvalid = 1'b1;
    repeat (5) @(negedge aclk);
    check("single_count", count_s, 6);
    check("single_errors", errors_s, 0);
    check("single_no_7th", ready_s, 0);
    tvalid = 1'b0;

    // ---- continuous wrap ----
    do_reset(32'd3);
    for (int i = 0; i < 8; i++) send_beat(1, 32'(i % 4));
    go_idle();
    check("wrap_count", count_c, 8);
    check("wrap_errors", errors_c, 0);
    check("wrap_done", done_c, 0);
    check("wrap_ready", ready_c, 1);

    // ---- mismatch and resync ----
    mis_seq = '{32'd0, 32'd1, 32'd2, 32'd7, 32'd8, 32'd9};
    do_reset(32'd9);
    for (int i = 0; i < 6; i++) send_beat(0, mis_seq[i]);
    go_idle();
    check("resync_errors", errors_s, 1);
    check("resync_count", count_s, 6);
    check("resync_done", done_s, 1);
    check("resync_ready", ready_s, 0);
    check("resync_eidx", eidx_s, FE ? 3 : 0);
    check("resync_edata", edata_s, FE ? 7 : 0);

    // ---- backpressure and gaps: tvalid pattern 1-0-0-1 ----
    do_reset(32'd4);
    val = '0;
    acc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (done_s) break;
      tvalid = ((k % 4) == 0) || ((k % 4) == 3);
      tdata  = val;
      if (tvalid && ready_s) begin
        val++;
        acc++;
      end
    end
    tvalid = 1'b0;
    @(negedge aclk);
    check("gaps_predicted", 64'(acc), 5);
    check("gaps_count", count_s, 5);
    check("gaps_errors", errors_s, 0);
    check("gaps_done", done_s, 1);

    // ---- zero config, then mid-run reset ----
    do_reset(32'd0);
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      saw = saw | ready_s | ready_c | ready_t;
    end
    check("zero_cfg_ready", saw, 0);
    cfg = 32'd10;
    for (int i = 0; i < 4; i++) send_beat(0, 32'(i));
    #1;
    check("midrun_count", count_s, 4);
    #2;
    areset = 1'b1;
    #1;
    check_single_zero("midreset");
    @(negedge aclk);
    check("reset_beat_ignored", count_s, 0);
    areset = 1'b0;
    tvalid = 1'b0;
    for (int i = 0; i <= 10; i++) send_beat(0, 32'(i));
    go_idle();
    check("fresh_count", count_s, 11);
    check("fresh_errors", errors_s, 0);
    check("fresh_done", done_s, 1);

    // ---- error saturation with a 2-bit counter ----
    sat_seq = '{32'd0, 32'd50, 32'd0, 32'd50, 32'd0, 32'd50};
    sat_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset(32'd100);
    for (int i = 0; i < 6; i++) begin
      send_beat(2, sat_seq[i]);
      #1;
      check($sformatf("sat_errors_%0d", i), errors_t, sat_exp[i]);
    end
    go_idle();
    check("sat_count", count_t, 6);
    check("sat_ready", ready_t, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_counter_checker.md
# axis_counter_checker

AXI4-Stream sink that consumes the ramp produced by the stream counter generator and verifies it beat by beat. It tracks the expected value, counts accepted beats and mismatches, and flags completion of a finite sequence. It sits at the receiving end of a loopback or DMA test path as a self-check sink for the counter generator.

## Interface
- AXIS_TDATA_WIDTH, 32: input stream width; only bits [CNTR_WIDTH-1:0] are compared.
- CNTR_WIDTH, 32: width of the expected-value register and of cfg_data; must be ≤ AXIS_TDATA_WIDTH.
- CONTINUOUS, "FALSE": "TRUE" means the ramp 0..cfg_data repeats forever; "FALSE" means one pass, then DONE.
- ERR_WIDTH, 16: width of the mismatch counter, which saturates.
- STS_WIDTH, 32: width of the beat counter, which wraps.
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- cfg_data  in  CNTR_WIDTH  last value of the ramp (N); registered internally once per cycle.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready, driven from the registered state.
- sts_count  out  STS_WIDTH  number of accepted beats.
- sts_errors  out  ERR_WIDTH  number of mismatching beats, saturating at all-ones.
- sts_done  out  1  single pass complete (CONTINUOUS = "FALSE" only).
- sts_err_index  out  STS_WIDTH  value of sts_count at the first mismatch.
- sts_err_data  out  CNTR_WIDTH  tdata received at the first mismatch.

## Operation
- Registers: cfg_reg (the registered copy of cfg_data), exp_reg, state.
- States are IDLE, RUN and DONE.
- IDLE:
  - s_axis_tready = 0.
  - Moves to RUN when cfg_reg ≠ 0; exp_reg = 0 on entry.
  - cfg_reg = 0 keeps the block in IDLE, matching a generator that emits nothing.
- RUN:
  - s_axis_tready = 1.
  - A beat is accepted when s_axis_tvalid & s_axis_tready.
- On each accepted beat with value d = tdata[CNTR_WIDTH-1:0]:
  - sts_count increments, wrapping modulo 2^STS_WIDTH.
  - If d ≠ exp_reg, sts_errors increments and saturates.
  - Resync: the next expected value is computed from d when d mismatches, otherwise from exp_reg. Call this base value r.
  - If r < cfg_reg, exp_reg becomes r + 1.
  - If r ≥ cfg_reg and CONTINUOUS = "TRUE", exp_reg becomes 0 and the block stays in RUN.
  - If r ≥ cfg_reg and CONTINUOUS = "FALSE", the block moves to DONE.
- DONE:
  - s_axis_tready = 0 and sts_done = 1.
  - Held until areset. Later changes to cfg_data are ignored.
- If cfg_data changes in RUN, the new N applies to comparisons from the second cycle after the change, because of the one-cycle register.
- A correct single pass therefore accepts N+1 beats, 0..N, with sts_errors = 0.

## Timing
- areset asserted: all registers clear immediately and asynchronously.
  - State goes to IDLE; s_axis_tready, sts_done, sts_count, sts_errors, sts_err_index and sts_err_data all become 0.
  - A beat presented during reset is not accepted.
- After reset deasserts:
  - cfg_reg loads on the first edge.
  - IDLE→RUN happens on the next edge.
  - s_axis_tready is high from the 2nd cycle after the first edge with nonzero cfg_data.
- Throughput is one beat per cycle while in RUN.
- Status latency: sts_count, sts_errors and sts_err_* update on the edge that accepts the beat and are visible the following cycle.
- Final beat, CONTINUOUS = "FALSE": s_axis_tready is low in the cycle after the beat with r ≥ cfg_reg is accepted, and sts_done rises in that same cycle.
- No combinational path exists from s_axis_tvalid to s_axis_tready.

## Configuration
- AXIS_COUNTER_CHECKER_FIRST_ERR_EN defined:
  - On the first mismatch only, sts_err_index captures the sts_count value before the increment and sts_err_data captures d.
  - Both fields hold until reset; later mismatches do not update them.
- Not defined: the capture logic is omitted and sts_err_index and sts_err_data are tied to 0.

## Test plan
- Single pass, correct ramp: CONTINUOUS = "FALSE", cfg_data = 5, source sends 0..5 with tvalid held high.
  - Expect 6 beats accepted, sts_count = 6, sts_errors = 0, sts_done = 1.
  - Expect tready = 0 afterwards; a 7th beat is never accepted.
- Wrap: CONTINUOUS = "TRUE", cfg_data = 3, source sends 0,1,2,3,0,1,2,3.
  - Expect sts_count = 8, sts_errors = 0, sts_done = 0, tready still 1.
- Mismatch and resync: cfg_data = 9, source sends 0,1,2,7,8,9, with AXIS_COUNTER_CHECKER_FIRST_ERR_EN defined.
  - Expect sts_errors = 1, sts_err_index = 3, sts_err_data = 7, sts_done = 1 after the beat with value 9.
- Backpressure and gaps: cfg_data = 4, tvalid toggled in a 1-0-0-1 pattern.
  - Expect only beats with tvalid & tready counted, final sts_count = 5, sts_errors = 0.
- Zero config and mid-run reset, cfg_data = 0:
  - Expect tready to stay 0 for 20 cycles.
  - Then set cfg_data = 10, accept 4 beats, and assert areset mid-cycle.
  - Expect all outputs 0 immediately, and a fresh pass 0..10 to give sts_count = 11.
- Error saturation: ERR_WIDTH = 2, CONTINUOUS = "TRUE", cfg_data = 100, source sends 0,50,0,50,0,50.
  - Expect sts_errors to stick at 3 and not wrap.
